// File: rtl/muldiv_sched_if.sv
// Issue handshake between the execute stage (master) and the mul/div sequencer (slave).
interface muldiv_sched_if;
  logic        issue_valid;
  logic [2:0]  issue_op;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic        issue_ready;

  modport master (
    output issue_valid, issue_op, issue_a, issue_b,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_op, issue_a, issue_b,
    output issue_ready
  );
endinterface

// File: rtl/muldiv_sched.sv
// Multiply/divide sequencer: owns HI/LO, drives a fixed-latency multiplier and a
// start/done divider, and cancels in-flight work on an exception flush.
module muldiv_sched #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  muldiv_sched_if.slave        issue,
  input  logic                 flush_i,
  input  logic                 stall_i,
  output logic                 busy_o,
  output logic                 mul_start_o,
  output logic [31:0]          mul_a_o,
  output logic [31:0]          mul_b_o,
  output logic                 mul_signed_o,
  input  logic [63:0]          mul_prod_i,
  output logic                 div_start_o,
  output logic                 div_abort_o,
  output logic [31:0]          div_a_o,
  output logic [31:0]          div_b_o,
  output logic                 div_signed_o,
  input  logic                 div_done_i,
  input  logic [31:0]          div_quot_i,
  input  logic [31:0]          div_rem_i,
  output logic [31:0]          hi_o,
  output logic [31:0]          lo_o,
  output logic [31:0]          mul_result_o,
  output logic                 mul_result_valid_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2,
    MUL_HOLD = 2'd3
  } state_e;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;
  localparam logic [3:0] LAT_INIT = 4'(MUL_LAT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, mul_result_q, mul_result_d;
  logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, div_a_q, div_a_d, div_b_q, div_b_d;
  logic        mul_signed_q, mul_signed_d, div_signed_q, div_signed_d;
  logic        mul_start_q, mul_start_d, div_start_q, div_start_d, div_abort_q, div_abort_d;
  logic        busy_q, busy_d, ready_q, ready_d, mres_valid_q, mres_valid_d;
  logic        accept_s, div_take_s;

  assign accept_s   = issue.issue_valid && (state_q == IDLE) && !flush_i;
  // div_start_q is high exactly in the first DIV_WAIT cycle, where done must be ignored
  assign div_take_s = (state_q == DIV_WAIT) && !div_start_q && div_done_i;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every state
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            case (issue.issue_op)
              OP_MULT, OP_MULTU, OP_MUL: state_d = MUL_WAIT;
              OP_DIV, OP_DIVU: begin
                if (issue.issue_b != 32'd0) begin
                  state_d = DIV_WAIT;
                end else begin
                  state_d = IDLE;
                end
              end
              default: state_d = IDLE;
            endcase
          end else begin
            state_d = IDLE;
          end
        end
        MUL_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_d = (op_q == OP_MUL) ? MUL_HOLD : IDLE;
          end else begin
            state_d = MUL_WAIT;
          end
        end
        DIV_WAIT: begin
          if (div_take_s) begin
            state_d = IDLE;
          end else begin
            state_d = DIV_WAIT;
          end
        end
        MUL_HOLD: begin
          if (!stall_i) begin
            state_d = IDLE;
          end else begin
            state_d = MUL_HOLD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output/datapath next values: operand capture, result capture, strobes
  always_comb begin
    cnt_d        = cnt_q;
    op_d         = op_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mul_result_d = mul_result_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    mul_signed_d = mul_signed_q;
    div_signed_d = div_signed_q;
    mul_start_d  = 1'b0;
    div_start_d  = 1'b0;
    div_abort_d  = 1'b0;
    if (flush_i) begin
      // results sampled in a flush cycle are discarded
      div_abort_d = (state_q == DIV_WAIT);
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            case (issue.issue_op)
              OP_MULT, OP_MULTU, OP_MUL: begin
                mul_a_d      = issue.issue_a;
                mul_b_d      = issue.issue_b;
                mul_signed_d = (issue.issue_op != OP_MULTU);
                op_d         = issue.issue_op;
                cnt_d        = LAT_INIT;
                mul_start_d  = 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                if (issue.issue_b != 32'd0) begin
                  div_a_d      = issue.issue_a;
                  div_b_d      = issue.issue_b;
                  div_signed_d = (issue.issue_op == OP_DIV);
                  div_start_d  = 1'b1;
                end else begin
                  div_start_d  = 1'b0;
                end
              end
              OP_MTHI: hi_d = issue.issue_a;
              OP_MTLO: lo_d = issue.issue_a;
              default: op_d = op_q;
            endcase
          end else begin
            op_d = op_q;
          end
        end
        MUL_WAIT: begin
          if (cnt_q == 4'd0) begin
            if (op_q == OP_MUL) begin
              mul_result_d = mul_prod_i[31:0];
            end else begin
              hi_d = mul_prod_i[63:32];
              lo_d = mul_prod_i[31:0];
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        DIV_WAIT: begin
          if (div_take_s) begin
            lo_d = div_quot_i;
            hi_d = div_rem_i;
          end else begin
            lo_d = lo_q;
          end
        end
        MUL_HOLD: cnt_d = cnt_q;
        default:  cnt_d = 4'd0;
      endcase
    end
    busy_d       = (state_d != IDLE);
    ready_d      = (state_d == IDLE);
    mres_valid_d = (state_d == MUL_HOLD);
  end

  // Datapath and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= 4'd0;
      op_q         <= 3'd0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      mul_result_q <= 32'd0;
      mul_a_q      <= 32'd0;
      mul_b_q      <= 32'd0;
      div_a_q      <= 32'd0;
      div_b_q      <= 32'd0;
      mul_signed_q <= 1'b0;
      div_signed_q <= 1'b0;
      mul_start_q  <= 1'b0;
      div_start_q  <= 1'b0;
      div_abort_q  <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
      mres_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mul_result_q <= mul_result_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      mul_signed_q <= mul_signed_d;
      div_signed_q <= div_signed_d;
      mul_start_q  <= mul_start_d;
      div_start_q  <= div_start_d;
      div_abort_q  <= div_abort_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      mres_valid_q <= mres_valid_d;
    end
  end

  assign issue.issue_ready  = ready_q;
  assign busy_o             = busy_q;
  assign mul_start_o        = mul_start_q;
  assign mul_a_o            = mul_a_q;
  assign mul_b_o            = mul_b_q;
  assign mul_signed_o       = mul_signed_q;
  assign div_start_o        = div_start_q;
  assign div_abort_o        = div_abort_q;
  assign div_a_o            = div_a_q;
  assign div_b_o            = div_b_q;
  assign div_signed_o       = div_signed_q;
  assign hi_o               = hi_q;
  assign lo_o               = lo_q;
  assign mul_result_o       = mul_result_q;
  assign mul_result_valid_o = mres_valid_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched with simple multiplier/divider models.
module tb_muldiv_sched;
  localparam int unsigned L = 2;

  logic        clk = 1'b0;
  logic        rst_n, flush, stall, force_done;
  logic        busy, mul_start, mul_signed, div_start, div_abort, div_signed, div_done;
  logic        mul_result_valid;
  logic [31:0] mul_a, mul_b, div_a, div_b, div_quot, div_rem, hi, lo, mul_result;
  logic [63:0] mul_prod, prod_full;
  logic [3:0]  mcnt, dcnt;
  logic [63:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  muldiv_sched_if ifc();

  muldiv_sched #(.MUL_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .issue(ifc.slave),
    .flush_i(flush), .stall_i(stall), .busy_o(busy),
    .mul_start_o(mul_start), .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_signed_o(mul_signed),
    .mul_prod_i(mul_prod),
    .div_start_o(div_start), .div_abort_o(div_abort), .div_a_o(div_a), .div_b_o(div_b),
    .div_signed_o(div_signed), .div_done_i(div_done), .div_quot_i(div_quot), .div_rem_i(div_rem),
    .hi_o(hi), .lo_o(lo), .mul_result_o(mul_result), .mul_result_valid_o(mul_result_valid)
  );

  // Multiplier model: product is only valid L cycles after the start cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcnt <= 4'd0;
    else if (mul_start) mcnt <= 4'd1;
    else if (mcnt == 4'(L)) mcnt <= 4'd0;
    else if (mcnt != 4'd0) mcnt <= mcnt + 4'd1;
  end

  always_comb begin
    prod_full = 64'd0;
    if (mul_signed) prod_full = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
    else            prod_full = {32'd0, mul_a} * {32'd0, mul_b};
  end
  assign mul_prod = (mcnt == 4'(L)) ? prod_full : 64'hDEAD_BEEF_DEAD_BEEF;

  // Divider model: done five cycles after the start cycle, cleared by abort
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dcnt <= 4'd0;
    else if (div_abort) dcnt <= 4'd0;
    else if (div_start) dcnt <= 4'd1;
    else if (dcnt == 4'd5) dcnt <= 4'd0;
    else if (dcnt != 4'd0) dcnt <= dcnt + 4'd1;
  end

  always_comb begin
    div_quot = 32'd0;
    div_rem  = 32'd0;
    if (div_b == 32'd0) begin
      div_quot = 32'd0;
    end else if (div_signed) begin
      div_quot = $signed(div_a) / $signed(div_b);
      div_rem  = $signed(div_a) % $signed(div_b);
    end else begin
      div_quot = div_a / div_b;
      div_rem  = div_a % div_b;
    end
  end
  assign div_done = (dcnt == 4'd5) || force_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    ifc.issue_valid = 1'b1;
    ifc.issue_op    = op;
    ifc.issue_a     = a;
    ifc.issue_b     = b;
    tick();
    ifc.issue_valid = 1'b0;
  endtask

  task automatic sb_check(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, {hi, lo}, e);
    end
  endtask

  initial begin
    int cyc;
    logic seen;
    rst_n = 1'b0; flush = 1'b0; stall = 1'b0; force_done = 1'b0;
    ifc.issue_valid = 1'b0; ifc.issue_op = 3'd0; ifc.issue_a = 32'd0; ifc.issue_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("rst_ready", ifc.issue_ready, 64'd1);
    check("rst_busy", busy, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_strobes", {mul_start, div_start, div_abort, mul_result_valid}, 64'd0);
    check("rst_ops", {mul_a, div_b}, 64'd0);

    // MULT -3 * 5
    exp_q.push_back(64'hFFFFFFFF_FFFFFFF1);
    issue(3'd0, 32'hFFFFFFFD, 32'd5);
    check("mult_c1_start", mul_start, 64'd1);
    check("mult_c1_busy", busy, 64'd1);
    check("mult_signed", mul_signed, 64'd1);
    tick();
    check("mult_c2_start", mul_start, 64'd0);
    check("mult_c2_busy", busy, 64'd1);
    tick();
    check("mult_c3_busy", busy, 64'd1);
    tick();
    check("mult_c4_busy", busy, 64'd0);
    check("mult_c4_ready", ifc.issue_ready, 64'd1);
    sb_check("mult_hilo");

    // MULTU back-to-back
    exp_q.push_back(64'h00000001_FFFFFFFE);
    issue(3'd1, 32'hFFFFFFFF, 32'd2);
    check("multu_signed", mul_signed, 64'd0);
    repeat (3) tick();
    check("multu_ready", ifc.issue_ready, 64'd1);
    sb_check("multu_hilo");

    // DIV -7 / 2, with a spurious done in the start cycle
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    force_done = 1'b1;
    check("div_c1_start", div_start, 64'd1);
    check("div_signed", div_signed, 64'd1);
    tick();
    force_done = 1'b0;
    check("div_c2_start", div_start, 64'd0);
    check("div_c2_busy", busy, 64'd1);
    cyc = 2;
    for (int i = 0; i < 20 && !ifc.issue_ready; i++) begin
      tick();
      cyc++;
    end
    check("div_ready", ifc.issue_ready, 64'd1);
    check("div_ready_cycle", 64'(cyc), 64'd7);
    sb_check("div_hilo");

    // MTHI/MTLO then DIV by zero
    issue(3'd4, 32'h1234, 32'd0);
    check("mthi_hi", hi, 64'h1234);
    check("mthi_busy", busy, 64'd0);
    issue(3'd5, 32'h5678, 32'd0);
    check("mtlo_lo", lo, 64'h5678);
    exp_q.push_back(64'h00001234_00005678);
    issue(3'd2, 32'd100, 32'd0);
    seen = div_start | busy;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | div_start | busy;
    end
    check("divz_activity", seen, 64'd0);
    sb_check("divz_hilo");

    // flush with issue in IDLE drops it; op 7 is ignored
    flush = 1'b1;
    issue(3'd4, 32'hAAAA, 32'd0);
    flush = 1'b0;
    issue(3'd7, 32'hBBBB, 32'd1);
    check("drop_busy", busy, 64'd0);
    check("drop_hilo", {hi, lo}, 64'h00001234_00005678);

    // MUL 7*6 with stall at completion
    exp_q.push_back(64'h00001234_00005678);
    stall = 1'b1;
    issue(3'd6, 32'd7, 32'd6);
    repeat (3) tick();
    check("mul_c4_valid", mul_result_valid, 64'd1);
    check("mul_c4_result", mul_result, 64'd42);
    check("mul_c4_busy", busy, 64'd1);
    tick();
    tick();
    check("mul_c6_valid", mul_result_valid, 64'd1);
    tick();
    stall = 1'b0;
    check("mul_c7_valid", mul_result_valid, 64'd1);
    tick();
    check("mul_c8_valid", mul_result_valid, 64'd0);
    check("mul_c8_ready", ifc.issue_ready, 64'd1);
    sb_check("mul_hilo");

    // DIVU flushed in its second cycle with done forced
    exp_q.push_back(64'h00001234_00005678);
    issue(3'd3, 32'd100, 32'd3);
    tick();
    flush = 1'b1;
    force_done = 1'b1;
    check("flush_c2_abort", div_abort, 64'd0);
    tick();
    flush = 1'b0;
    force_done = 1'b0;
    check("flush_abort", div_abort, 64'd1);
    check("flush_ready", ifc.issue_ready, 64'd1);
    sb_check("flush_hilo");
    tick();
    check("flush_abort_once", div_abort, 64'd0);

    // asynchronous reset mid-MULT
    issue(3'd0, 32'd3, 32'd4);
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_hilo", {hi, lo}, 64'd0);
    check("arst_mulres", mul_result, 64'd0);
    check("arst_ops", {mul_a, mul_b}, 64'd0);
    check("arst_flags", {busy, mul_start, mul_signed, mul_result_valid}, 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("arst_ready", ifc.issue_ready, 64'd1);
    check("arst_hilo_after", {hi, lo}, 64'd0);
    check("arst_abort", div_abort, 64'd0);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Sequencer and owner of the HI/LO state for the execute-stage multiply/divide resource. It accepts one operation at a time from the execute stage and drives a fixed-latency external multiplier and a start/done external divider. It captures results into HI/LO or a GPR result register, reports busy to the hazard logic, and cancels in-flight work on an exception flush.

## Interface
- MUL_LAT, 2: multiplier latency in cycles from the `mul_start` cycle to a valid `mul_prod` (legal range 1..15).
- Clk  in  1  clock, rising edge.
- Clr_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  request from execute stage; accepted only when issue_ready=1 and flush=0.
- issue_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MUL (to GPR); 7 is ignored.
- issue_a, issue_b  in  32  operands (rs, rt).
- issue_ready  out  1  state==IDLE.
- busy  out  1  state!=IDLE; hazard unit stalls mfhi/mflo/issue while high.
- flush  in  1  exception flush; cancels the in-flight operation.
- stall  in  1  downstream stall; holds the MUL result.
- mul_start  out  1  one-cycle start strobe.
- mul_a, mul_b  out  32  registered operands.
- mul_signed  out  1  registered.
- mul_prod  in  64  product.
- div_start  out  1  one-cycle start strobe.
- div_abort  out  1  one-cycle abort strobe.
- div_a, div_b  out  32  registered operands.
- div_signed  out  1  registered.
- div_done  in  1  divider done.
- div_quot, div_rem  in  32  divider results.
- hi, lo  out  32  architectural HI/LO.
- mul_result  out  32  low word for the MUL instruction.
- mul_result_valid  out  1  high while in MUL_HOLD.

## Operation
- States: IDLE, MUL_WAIT, DIV_WAIT, MUL_HOLD. 4-bit down-counter `cnt`.
- IDLE, accepted MULT/MULTU/MUL:
  - Latch operands to mul_a/mul_b.
  - mul_signed = (op != MULTU).
  - Remember the op; set cnt=MUL_LAT.
  - Next state is MUL_WAIT, with mul_start=1 in its first cycle.
- MUL_WAIT: cnt decrements each cycle after the start cycle. In the cycle where cnt==0, sample mul_prod:
  - MULT/MULTU: HI=prod[63:32], LO=prod[31:0], then IDLE.
  - MUL: mul_result=prod[31:0], HI/LO unchanged, then MUL_HOLD.
- MUL_HOLD: mul_result_valid=1. Go to IDLE at the end of the first cycle with stall=0.
- IDLE, accepted DIV/DIVU with issue_b!=0:
  - Latch operands to div_a/div_b.
  - div_signed = (op==DIV).
  - Next state is DIV_WAIT, with div_start=1 in its first cycle.
- DIV_WAIT: div_done is ignored in the div_start cycle. On the first later cycle with div_done=1: LO=div_quot, HI=div_rem, then IDLE.
- DIV/DIVU with issue_b==0: no divider activity, HI/LO unchanged, stay IDLE, busy never asserts.
- MTHI/MTLO in IDLE: HI (or LO) = issue_a at the clock edge; stay IDLE.
- issue_valid while not IDLE, or with op 7: ignored, no state change.
- flush:
  - Highest priority; applies in any state.
  - Next state is IDLE; any result sampled that cycle is discarded; HI/LO keep their prior values.
  - flush in DIV_WAIT (including the start cycle): div_abort=1 in the next cycle.
  - flush together with issue_valid in IDLE: the issue is dropped.
- Strobes mul_start, div_start and div_abort are registered and last exactly one cycle.
- Reset (asynchronous, any state, including mid-operation):
  - State IDLE, cnt=0.
  - hi, lo, mul_result, mul_a, mul_b, div_a, div_b all 0.
  - All strobes, mul_signed, div_signed and mul_result_valid 0.
  - issue_ready=1 once reset is released.
  - Any in-flight divider result is ignored; div_abort is not asserted by reset.

## Timing
- Issue at cycle 0 (MULT, MUL_LAT=L):
  - mul_start in cycle 1; mul_prod sampled at the end of cycle 1+L.
  - HI/LO new values visible in cycle 2+L.
  - busy high in cycles 1..1+L; issue_ready high again in cycle 2+L (a back-to-back issue is legal there).
- MUL: mul_result_valid from cycle 2+L until the end of the first non-stalled cycle; busy stays high over the same span.
- DIV: div_start in cycle 1. If div_done is first seen in cycle k≥2, HI/LO update at the end of cycle k and issue_ready=1 in k+1.
- MTHI/MTLO: 0 busy cycles; the new value is visible in cycle 1.
- Flush in cycle f: IDLE and issue_ready=1 in f+1; div_abort (if applicable) in f+1.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=5, L=2 → mul_start in cycle 1, busy cycles 1–3; cycle 4: HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU a=0xFFFFFFFF, b=2 → HI=0x00000001, LO=0xFFFFFFFE; mul_signed=0.
- DIV a=0xFFFFFFF9 (−7), b=2, divider model done after 5 cycles → div_start in cycle 1; LO=0xFFFFFFFD, HI=0xFFFFFFFF; busy deasserts the cycle after div_done.
- DIV b=0 with HI=0x1234, LO=0x5678 preloaded via MTHI/MTLO → no div_start, busy never high, HI/LO unchanged.
- MUL 7×6 with stall held 3 cycles at completion → mul_result=42, valid held through the stall and dropped after the first unstalled cycle; HI/LO unchanged.
- DIV then flush in the second DIV_WAIT cycle, with div_done forced in the same cycle → div_abort pulse next cycle, HI/LO unchanged, issue_ready=1. Repeat with Clr_n pulsed low mid-MULT → all outputs 0 immediately.
